// File: rtl/cu_seq.sv
// cu_seq: microcode sequencer for the jrb8 CPU (FETCH/EXEC/ALU_WAIT/COMMIT/HALTED).
// Optional ALU wait timeout with sticky alu_err is enabled by defining CU_ALU_TIMEOUT_EN.
module cu_seq #(
  parameter int                 IR_W        = 10,
  parameter int                 PC_W        = 23,
  parameter int                 FLAGS_W     = 27,
  parameter int                 NUM_PHASES  = 4,
  parameter int                 PH_W        = 3,
  parameter logic [FLAGS_W-1:0] FETCH_FLAGS = '0,
  parameter int                 PCC_BIT     = 0,
  parameter int                 ALUO_BIT    = 1,
  parameter int                 HALT_BIT    = 2,
  parameter int                 LAST_BIT    = 3,
  parameter int                 ALU_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_ready,
  input  logic                 resume,
  input  logic [IR_W-1:0]      ir_in,
  input  logic                 pc_load,
  input  logic [PC_W-1:0]      pc_in,
  output logic [PH_W+IR_W-1:0] uc_addr,
  input  logic [FLAGS_W-1:0]   uc_data,
  output logic                 alu_start,
  input  logic                 alu_done,
  output logic [IR_W-1:0]      ir,
  output logic [PC_W-1:0]      pc,
  output logic [PH_W-1:0]      phase,
  output logic [FLAGS_W-1:0]   flags,
  output logic                 write_en,
  output logic                 halted,
  output logic                 alu_err,
  output logic [2:0]           o_dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_EXEC     = 3'd1,
    S_ALU_WAIT = 3'd2,
    S_COMMIT   = 3'd3,
    S_HALTED   = 3'd4
  } state_t;

  if (NUM_PHASES < 2 || NUM_PHASES > 8 || (2 ** PH_W) < NUM_PHASES || ALU_TIMEOUT < 1) begin : g_bad_cfg
    $error("cu_seq: illegal parameter combination");
  end

  state_t          r_state, w_next;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic [IR_W-1:0] r_ir, w_ir_nxt;
  logic [PH_W-1:0] r_phase, w_phase_nxt;
  logic            r_resume_exec, w_resume_exec_nxt;
  logic            w_last, w_to_hit, w_alu_start, w_write_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_pc          <= '0;
      r_ir          <= '0;
      r_phase       <= '0;
      r_resume_exec <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_pc          <= w_pc_nxt;
      r_ir          <= w_ir_nxt;
      r_phase       <= w_phase_nxt;
      r_resume_exec <= w_resume_exec_nxt;
    end
  end

  assign w_last = uc_data[LAST_BIT] || (r_phase == PH_W'(NUM_PHASES - 1));

  // With mem_ready low every next value defaults to its current value (full freeze).
  always_comb begin
    w_next            = r_state;
    w_pc_nxt          = r_pc;
    w_ir_nxt          = r_ir;
    w_phase_nxt       = r_phase;
    w_resume_exec_nxt = r_resume_exec;
    w_alu_start       = 1'b0;
    w_write_en        = 1'b0;
    if (mem_ready) begin
      case (r_state)
        S_FETCH: begin
          w_ir_nxt    = ir_in;
          w_pc_nxt    = r_pc + PC_W'(1);
          w_phase_nxt = '0;
          w_next      = S_EXEC;
        end
        S_EXEC: begin
          if (uc_data[PCC_BIT]) w_pc_nxt = r_pc + PC_W'(1);
          if (uc_data[ALUO_BIT]) begin
            w_alu_start = 1'b1;
            w_next      = S_ALU_WAIT;
          end else begin
            w_next = S_COMMIT;
          end
        end
        S_ALU_WAIT: begin
          if (alu_done || w_to_hit) w_next = S_COMMIT;
        end
        S_COMMIT: begin
          w_write_en = 1'b1;
          if (w_last) begin
            if (pc_load) w_pc_nxt = pc_in;
            w_resume_exec_nxt = 1'b0;
            w_next            = uc_data[HALT_BIT] ? S_HALTED : S_FETCH;
          end else if (uc_data[HALT_BIT]) begin
            w_resume_exec_nxt = 1'b1;
            w_next            = S_HALTED;
          end else begin
            w_phase_nxt = r_phase + PH_W'(1);
            w_next      = S_EXEC;
          end
        end
        S_HALTED: begin
          // A mid-instruction halt resumes at the following phase of the same instruction.
          if (resume) begin
            if (r_resume_exec) begin
              w_phase_nxt = r_phase + PH_W'(1);
              w_next      = S_EXEC;
            end else begin
              w_next = S_FETCH;
            end
          end
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

`ifdef CU_ALU_TIMEOUT_EN
  localparam int TO_W = $clog2(ALU_TIMEOUT + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_alu_err;

  assign w_to_hit = (r_state == S_ALU_WAIT) && (r_to_cnt == TO_W'(ALU_TIMEOUT - 1));

  // Counter sits at zero outside ALU_WAIT, so it is clear on every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_alu_err <= 1'b0;
    end else if (mem_ready) begin
      if (r_state != S_ALU_WAIT) r_to_cnt <= '0;
      else                       r_to_cnt <= r_to_cnt + TO_W'(1);
      if (w_to_hit && !alu_done) r_alu_err <= 1'b1;
    end
  end

  assign alu_err = r_alu_err;
`else
  assign w_to_hit = 1'b0;
  assign alu_err  = 1'b0;
`endif

  always_comb begin
    case (r_state)
      S_FETCH:  flags = FETCH_FLAGS;
      S_HALTED: flags = '0;
      default:  flags = uc_data;
    endcase
  end

  assign uc_addr     = {r_phase, r_ir};
  assign alu_start   = w_alu_start;
  assign write_en    = w_write_en;
  assign halted      = (r_state == S_HALTED);
  assign ir          = r_ir;
  assign pc          = r_pc;
  assign phase       = r_phase;
  assign o_dbg_state = r_state;

endmodule

// File: doc/cu_seq.md
Name: cu_seq

Overview:
Parametrised microcode sequencer, the next-generation control unit for the jrb8 CPU.
- Latches the instruction register and walks up to NUM_PHASES microcode phases per instruction, where the current unit is fixed at two.
- Drives the program counter and write strobes.
- Handshakes with the multi-cycle ALU using explicit start/done pulses.
- Adds a memory stall input and a resumable halt state.
- The microcode ROM is external: the block presents an address and reads back combinational data.

Parameters:
IR_W, 10, instruction register width
PC_W, 23, program counter width
FLAGS_W, 27, microcode word / flags width
NUM_PHASES, 4, max microcode phases per instruction (2..8)
PH_W, 3, phase index width; must satisfy 2**PH_W >= NUM_PHASES
FETCH_FLAGS, 27'h0, flags word driven during FETCH
PCC_BIT, 0, flag bit: count PC in EXEC
ALUO_BIT, 1, flag bit: phase uses ALU
HALT_BIT, 2, flag bit: halt after this phase
LAST_BIT, 3, flag bit: this phase terminates the instruction
ALU_TIMEOUT, 255, ALU wait limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_ready  in  1  0 = stall all sequencing this cycle
resume  in  1  pulse; leave HALTED
ir_in  in  IR_W  instruction byte from memory
pc_load  in  1  load pc_in at the end of the instruction
pc_in  in  PC_W  jump target
uc_addr  out  PH_W+IR_W  {phase, ir} to the microcode ROM
uc_data  in  FLAGS_W  microcode word (combinational)
alu_start  out  1  one-cycle ALU start pulse
alu_done  in  1  one-cycle ALU completion pulse
ir  out  IR_W  latched instruction
pc  out  PC_W  program counter
phase  out  PH_W  current phase index
flags  out  FLAGS_W  active control flags
write_en  out  1  commit strobe
halted  out  1  sequencer in HALTED
alu_err  out  1  sticky ALU timeout flag

Behaviour:
- Reset (sync, rst=1 at clk edge), from any state including mid-ALU-wait:
  - State goes to FETCH.
  - pc=0, ir=0, phase=0, alu_err=0.
  - alu_start=0, write_en=0, halted=0.
- States: FETCH, EXEC, ALU_WAIT, COMMIT, HALTED.
- Stall: mem_ready=0 freezes state, pc, ir, phase and the timeout counter, and forces alu_start=0 and write_en=0. Reset overrides stall.
- flags = FETCH_FLAGS in FETCH, 0 in HALTED, uc_data otherwise. uc_addr = {phase, ir} at all times.
- FETCH (1 cycle): ir<=ir_in; pc<=pc+1; phase<=0; next state EXEC.
- EXEC (1 cycle):
  - If PCC: pc<=pc+1.
  - If ALUO: alu_start=1 this cycle, next state ALU_WAIT.
  - Otherwise next state COMMIT.
- ALU_WAIT:
  - Remain until alu_done=1, then go to COMMIT.
  - alu_done is sampled only in ALU_WAIT; a done pulse in any other state is ignored.
  - A done pulse arriving the cycle after alu_start is legal and gives a 1-cycle wait.
- COMMIT (1 cycle): write_en=1. The phase is terminating if LAST=1 or phase==NUM_PHASES-1.
  - Terminating phase: if pc_load, pc<=pc_in. Next state HALTED if HALT=1, else FETCH.
  - Non-terminating phase, HALT=0: phase<=phase+1, next state EXEC.
  - Non-terminating phase, HALT=1: next state HALTED. phase is preserved, and resume continues at EXEC with phase+1.
- HALTED: halted=1; pc and ir hold. resume=1 with mem_ready=1 leaves HALTED the next cycle. resume is ignored in all other states.
- PC arithmetic is modulo 2**PC_W; all-ones + 1 wraps to 0. If pc_load and PCC apply in the same instruction, the COMMIT load wins because it occurs later.
- Minimum instruction length, 1 phase, no ALU: FETCH, EXEC, COMMIT = 3 cycles. Each extra non-ALU phase adds 2 cycles.

Optional Feature:
CU_ALU_TIMEOUT_EN
- Defined: a counter clears on entry to ALU_WAIT and increments each non-stalled cycle. When it reaches ALU_TIMEOUT without alu_done, the sequencer goes to COMMIT and sets alu_err=1. alu_err stays set until reset.
- Undefined: no counter; ALU_WAIT waits indefinitely; alu_err is tied to 0.

Test Plan:
- Reset, then 2-phase instruction ir_in=10'h012 with LAST on phase 1 and no ALU → pc 0→1; write_en pulses at cycles 3 and 5; phase goes 0,1; back to FETCH at cycle 6.
- ALUO on phase 0, alu_done returned 4 cycles after alu_start → exactly one alu_start pulse; COMMIT the cycle after done; a stray alu_done during EXEC is ignored.
- pc_load=1, pc_in=23'h7FFFF0 with PCC set in EXEC → pc=23'h7FFFF0 after COMMIT; separately, pc=23'h7FFFFF plus FETCH → pc=0.
- HALT flag in phase 0 of a 3-phase instruction → halted=1 with pc held; resume after 10 cycles → EXEC at phase 1; resume during EXEC has no effect.
- mem_ready=0 for 3 cycles during ALU_WAIT, then rst=1 mid-wait → no state or pc change while stalled; after reset, state FETCH, pc=0, alu_start=0.
- With CU_ALU_TIMEOUT_EN and ALU_TIMEOUT=8, alu_done never asserted → COMMIT after 8 wait cycles; alu_err=1 and stays 1 across the next instruction.
